mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control FSM. It is the initiator on the ALU interface: it drives the 3-bit ALU op select and consumes the ALU z/c/v flags.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects and write enables.
- Sits between the instruction register (opcode/funct) and the multi-cycle datapath.

Parameters:
- SUPPORT_NOT, 1: 1 = R-type funct 6'h27 executes ALU NOT; 0 = funct 6'h27 is illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26], stable from FETCH+1 onward
- funct  in  6  IR[5:0]
- alu_z  in  1  ALU zero flag
- alu_c  in  1  ALU carry/borrow flag (captured only)
- alu_v  in  1  ALU overflow flag
- alu_sel  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
- pc_write  out  1  PC load enable
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- carry_q  out  1  alu_c registered at end of last R/I execute
- exc_cause  out  2  00 none, 01 illegal opcode, 10 overflow; updated on EXC entry only
- state_o  out  4  current state (debug)

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, EXC=13. Codes 14–15 go to FETCH.
- rst=1 at a clock edge: state=RST, carry_q=0, exc_cause=00. This applies in every state, including mid-instruction; an in-flight write in the current state is not re-issued.
- RST: all outputs 0; next state FETCH.
- Outputs are decoded from the registered state (Moore), except pc_write in BRANCH, which depends on alu_z. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_sel=ADD, pc_source=00, pc_write=1. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_sel=ADD (branch target into ALUOut). Latch opcode/funct internally.
  - opcode 23 or 2B -> MEM_ADDR
  - opcode 00 with legal funct -> R_EXEC
  - opcode 04 -> BRANCH
  - opcode 02 -> JUMP
  - opcode 08 -> I_EXEC
  - anything else -> EXC with cause 01
- Legal funct values: 20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOT (only if SUPPORT_NOT=1). Any other funct -> EXC, cause 01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_sel=ADD. Next: MEM_RD for opcode 23, MEM_WR for opcode 2B.
- MEM_RD: mem_read=1, iord=1. Next: MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write=1, iord=1. Next: FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_sel decoded from latched funct; carry_q<=alu_c. Next: R_WB (overflow exception: see Optional Feature).
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=SUB, pc_source=01, pc_write=alu_z. Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_sel=ADD; carry_q<=alu_c. Next: I_WB.
- I_WB: reg_write=1, reg_dst=0. Next: FETCH.
- EXC: pc_source=11, pc_write=1. Next: FETCH.
- Latency, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, exception 3.
- reg_write and mem_write are never asserted in the same cycle. reg_write is never asserted in EXC.

Optional Feature:
- Macro: MC_CONTROL_OVF_TRAP_EN.
- Defined: in R_EXEC with latched funct 20 or 22, and in I_EXEC, alu_v=1 sends the FSM to EXC with exc_cause<=10 instead of R_WB/I_WB. No register writeback occurs.
- Undefined: alu_v is ignored and writeback proceeds. exc_cause can only become 01.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0 and state_o=0 during reset; state_o=1 with mem_read=ir_write=pc_write=1 on the first cycle after release.
- R-type funct 22 -> states 1,2,7,8,1; alu_sel=001 in R_EXEC; reg_write=1 and reg_dst=1 only in R_WB.
- lw (23) then sw (2B) -> lw visits 1,2,3,4,5 with mem_to_reg=1 in state 5; sw visits 1,2,3,6 with mem_write=1 only in state 6.
- beq (04) with alu_z=1 -> pc_write=1, pc_source=01 in BRANCH; repeated with alu_z=0 -> pc_write=0 in BRANCH.
- opcode 3F -> EXC, exc_cause=01, pc_source=11, pc_write=1, reg_write never 1; funct 27 with SUPPORT_NOT=0 gives the same response.
- Macro defined, add (funct 20) with alu_v=1 in R_EXEC -> EXC, exc_cause=10, no reg_write. Macro undefined, same stimulus -> R_WB with reg_write=1.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for a MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath
// mux selects and write enables, and issues the 3-bit ALU op select.
// Optional build macro MC_CONTROL_OVF_TRAP_EN: when defined, signed
// overflow (alu_v) on add/sub/addi traps to EXC with cause 10 instead of
// writing back; when undefined, alu_v is ignored.
module mc_control #(
  parameter bit SUPPORT_NOT = 1'b1  // 1: funct 6'h27 executes ALU NOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       carry_q,
  output logic [1:0] exc_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_EXC      = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOT = 6'h27;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic [5:0] r_funct;
  logic       r_carry;
  logic [1:0] r_exc_cause;
  logic       w_funct_legal;
  logic       w_r_ovf;
  logic       w_i_ovf;
  logic [1:0] w_exc_code;

  // Legal R-type function codes; NOT only when the build supports it.
  assign w_funct_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                         (funct == FN_AND) || (funct == FN_OR)  ||
                         (SUPPORT_NOT && (funct == FN_NOT));

`ifdef MC_CONTROL_OVF_TRAP_EN
  // Only signed arithmetic (add, sub, addi) can trap on overflow.
  assign w_r_ovf    = alu_v && ((r_funct == FN_ADD) || (r_funct == FN_SUB));
  assign w_i_ovf    = alu_v;
  // EXC reached from DECODE is an illegal instruction; from execute it is overflow.
  assign w_exc_code = (r_state == S_DECODE) ? 2'b01 : 2'b10;
`else
  logic w_unused;
  assign w_unused   = alu_v;
  assign w_r_ovf    = 1'b0;
  assign w_i_ovf    = 1'b0;
  assign w_exc_code = 2'b01;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_RST;
    else     r_state <= w_next;
  end

  // Instruction fields captured in DECODE for use by later states.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always written in DECODE before any state reads them.
    if (r_state == S_DECODE) begin
      r_opcode <= opcode;
      r_funct  <= funct;
    end
  end

  // Carry capture at the end of execute and exception cause on EXC entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry     <= 1'b0;
      r_exc_cause <= 2'b00;
    end else begin
      if ((r_state == S_R_EXEC) || (r_state == S_I_EXEC)) r_carry <= alu_c;
      if (w_next == S_EXC) r_exc_cause <= w_exc_code;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next = S_FETCH;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = w_funct_legal ? S_R_EXEC : S_EXC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_I_EXEC;
          default:      w_next = S_EXC;
        endcase
      end
      S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = S_FETCH;
      S_R_EXEC:   w_next = w_r_ovf ? S_EXC : S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = w_i_ovf ? S_EXC : S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_EXC:      w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore output decode; BRANCH's pc_write follows the ALU zero flag.
  always_comb begin
    alu_sel    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        case (r_funct)
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_NOT:  alu_sel = ALU_NOT;
          default: alu_sel = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = alu_z;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB: reg_write = 1'b1;
      S_EXC: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign carry_q   = r_carry;
  assign exc_cause = r_exc_cause;
  assign state_o   = r_state;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. Two instances share the
// stimulus: one with SUPPORT_NOT=1 and one with SUPPORT_NOT=0. Expected
// per-cycle state/outputs are queued when an instruction is issued and
// popped as the DUTs step. Honours MC_CONTROL_OVF_TRAP_EN like the RTL.
module tb_mc_control;

`ifdef MC_CONTROL_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_z = 1'b0;
  logic       alu_c = 1'b0;
  logic       alu_v = 1'b0;

  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, carry_q;
  logic [1:0] exc_cause;
  logic [3:0] state_o;

  logic [2:0] nn_alu_sel;
  logic       nn_alu_src_a;
  logic [1:0] nn_alu_src_b;
  logic [1:0] nn_pc_source;
  logic       nn_pc_write, nn_iord, nn_mem_read, nn_mem_write, nn_ir_write;
  logic       nn_reg_dst, nn_mem_to_reg, nn_reg_write, nn_carry_q;
  logic [1:0] nn_exc_cause;
  logic [3:0] nn_state_o;

  mc_control #(.SUPPORT_NOT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .carry_q(carry_q), .exc_cause(exc_cause), .state_o(state_o)
  );

  mc_control #(.SUPPORT_NOT(1'b0)) u_dut_nn (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_sel(nn_alu_sel), .alu_src_a(nn_alu_src_a), .alu_src_b(nn_alu_src_b),
    .pc_source(nn_pc_source), .pc_write(nn_pc_write), .iord(nn_iord),
    .mem_read(nn_mem_read), .mem_write(nn_mem_write), .ir_write(nn_ir_write),
    .reg_dst(nn_reg_dst), .mem_to_reg(nn_mem_to_reg), .reg_write(nn_reg_write),
    .carry_q(nn_carry_q), .exc_cause(nn_exc_cause), .state_o(nn_state_o)
  );

  always #5 clk = ~clk;

  // Control outputs packed in a fixed order for one-shot comparison.
  logic [15:0] ctrl, nn_ctrl;
  assign ctrl = {alu_sel, alu_src_a, alu_src_b, pc_source, pc_write, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write};
  assign nn_ctrl = {nn_alu_sel, nn_alu_src_a, nn_alu_src_b, nn_pc_source, nn_pc_write,
                    nn_iord, nn_mem_read, nn_mem_write, nn_ir_write, nn_reg_dst,
                    nn_mem_to_reg, nn_reg_write};

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        carry;
    logic [1:0]  exc;
  } rec_t;

  rec_t       q_main[$];
  rec_t       q_nn[$];
  logic       m_carry [0:1];
  logic [1:0] m_exc   [0:1];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected control vector for a state, straight from the state table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn,
                                           input logic z);
    logic [2:0] sel;
    logic       src_a, pcw, io, mr, mw, irw, rdst, m2r, rw;
    logic [1:0] src_b, pcs;
    sel = 3'b000; src_a = 0; src_b = 2'b00; pcs = 2'b00;
    pcw = 0; io = 0; mr = 0; mw = 0; irw = 0; rdst = 0; m2r = 0; rw = 0;
    case (st)
      4'd1:  begin mr = 1; irw = 1; src_b = 2'b01; pcw = 1; end
      4'd2:  src_b = 2'b11;
      4'd3:  begin src_a = 1; src_b = 2'b10; end
      4'd4:  begin mr = 1; io = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; io = 1; end
      4'd7:  begin
        src_a = 1;
        case (fn)
          6'h22:   sel = 3'b001;
          6'h24:   sel = 3'b010;
          6'h25:   sel = 3'b011;
          6'h27:   sel = 3'b100;
          default: sel = 3'b000;
        endcase
      end
      4'd8:  begin rw = 1; rdst = 1; end
      4'd9:  begin src_a = 1; sel = 3'b001; pcs = 2'b01; pcw = z; end
      4'd10: begin pcs = 2'b10; pcw = 1; end
      4'd11: begin src_a = 1; src_b = 2'b10; end
      4'd12: rw = 1;
      4'd13: begin pcs = 2'b11; pcw = 1; end
      default: ;
    endcase
    return {sel, src_a, src_b, pcs, pcw, io, mr, mw, irw, rdst, m2r, rw};
  endfunction

  // Build the expected per-cycle records for one instruction into one model's queue.
  task automatic push_path(input int which, input bit support, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input logic c, input logic v);
    logic [3:0] path[$];
    bit         legal_r, ovf;
    rec_t       r;
    legal_r = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) ||
              (support && fn == 6'h27);
    ovf = TRAP && v && ((op == 6'h08) || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)));
    path.push_back(4'd1);
    path.push_back(4'd2);
    case (op)
      6'h23: begin path.push_back(4'd3); path.push_back(4'd4); path.push_back(4'd5); end
      6'h2B: begin path.push_back(4'd3); path.push_back(4'd6); end
      6'h00: begin
        if (legal_r) begin path.push_back(4'd7); path.push_back(ovf ? 4'd13 : 4'd8); end
        else path.push_back(4'd13);
      end
      6'h04: path.push_back(4'd9);
      6'h02: path.push_back(4'd10);
      6'h08: begin path.push_back(4'd11); path.push_back(ovf ? 4'd13 : 4'd12); end
      default: path.push_back(4'd13);
    endcase
    for (int i = 0; i < path.size(); i++) begin
      if (path[i] == 4'd13) m_exc[which] = (path[i-1] == 4'd2) ? 2'b01 : 2'b10;
      r.st    = path[i];
      r.ctrl  = exp_ctrl(path[i], fn, z);
      r.carry = m_carry[which];
      r.exc   = m_exc[which];
      if (which == 0) q_main.push_back(r);
      else            q_nn.push_back(r);
      if (path[i] == 4'd7 || path[i] == 4'd11) m_carry[which] = c;
    end
  endtask

  // Issue one instruction, then pop and compare one record per cycle (cut>0 stops early).
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic c, input logic v, input int cut);
    rec_t rm, rn;
    int   n;
    opcode = op; funct = fn; alu_z = z; alu_c = c; alu_v = v;
    push_path(0, 1'b1, op, fn, z, c, v);
    push_path(1, 1'b0, op, fn, z, c, v);
    n = (q_main.size() < q_nn.size()) ? q_main.size() : q_nn.size();
    if (cut > 0 && cut < n) n = cut;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rm = q_main.pop_front();
      rn = q_nn.pop_front();
      check($sformatf("%s c%0d state", name, i), 32'(state_o), 32'(rm.st));
      check($sformatf("%s c%0d ctrl", name, i), 32'(ctrl), 32'(rm.ctrl));
      check($sformatf("%s c%0d carry_q", name, i), 32'(carry_q), 32'(rm.carry));
      check($sformatf("%s c%0d exc_cause", name, i), 32'(exc_cause), 32'(rm.exc));
      check($sformatf("%s c%0d nn_state", name, i), 32'(nn_state_o), 32'(rn.st));
      check($sformatf("%s c%0d nn_ctrl", name, i), 32'(nn_ctrl), 32'(rn.ctrl));
      check($sformatf("%s c%0d nn_exc_cause", name, i), 32'(nn_exc_cause), 32'(rn.exc));
    end
    q_main.delete();
    q_nn.delete();
  endtask

  // Hold reset for a number of cycles, checking the reset state each cycle.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst state", 32'(state_o), 32'd0);
      check("rst ctrl", 32'(ctrl), 32'd0);
      check("rst carry_q", 32'(carry_q), 32'd0);
      check("rst exc_cause", 32'(exc_cause), 32'd0);
      check("rst nn_state", 32'(nn_state_o), 32'd0);
      check("rst nn_exc_cause", 32'(nn_exc_cause), 32'd0);
    end
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_carry[w] = 1'b0;
      m_exc[w]   = 2'b00;
    end
  endtask

  initial begin
    do_reset(2);
    run_instr("sub",      6'h00, 6'h22, 1'b0, 1'b1, 1'b0, 0);
    run_instr("lw",       6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("sw",       6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("beq_z1",   6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 0);
    run_instr("beq_z0",   6'h04, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("ill_op",   6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("add_ovf",  6'h00, 6'h20, 1'b0, 1'b0, 1'b1, 0);
    run_instr("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, 0);
    run_instr("addi",     6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("and_ovf",  6'h00, 6'h24, 1'b0, 1'b1, 1'b1, 0);
    run_instr("or",       6'h00, 6'h25, 1'b0, 1'b0, 1'b0, 0);
    run_instr("ill_fn",   6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 0);
    run_instr("j",        6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    // Abort a store before its write state; reset must suppress MEM_WR.
    run_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3);
    do_reset(1);
    // NOT: legal on the main instance, illegal on the SUPPORT_NOT=0 instance.
    run_instr("not",      6'h00, 6'h27, 1'b0, 1'b1, 1'b0, 3);
    do_reset(1);
    run_instr("j_after",  6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
